qbus_ctl: RTL and testbench
===========================

# qbus_ctl

Q-bus (MPI) cycle sequencer and bus-master arbiter for the VM2 CPU core. It accepts single-word or single-byte read/write requests from the core and runs the SYNC/DIN/DOUT/RPLY handshake on the multiplexed AD bus. It grants the bus to a DMA master (DMR/DMGO/SACK) between CPU cycles and aborts a cycle with an error when RPLY does not arrive in time. It sits between the core's fetch/operand state machine and the board-level bus pads.

## Interface
- TIMEOUT, 64: cycles allowed waiting for RPLY assert (DATA) or deassert (RELEASE); minimum 4.
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  core bus request; sampled only in IDLE.
- we  in  1  1 = write (DATO/DATOB), 0 = read (DATI).
- byte  in  1  byte write; drives wtbt in the data phase.
- addr  in  16  bus address.
- wdata  in  16  write data.
- rdata  out  16  read data, valid in the ack cycle and held until the next read.
- ack  out  1  one-cycle pulse: cycle finished.
- err  out  1  one-cycle pulse with ack: RPLY timeout.
- busy  out  1  high in every state except IDLE.
- ad_in  in  16  AD bus from pads.
- ad_out  out  16  AD bus to pads.
- ad_oe  out  1  AD output enable.
- sync, din, dout, wtbt  out  1 each  bus controls, active-high at this boundary; pad inversion is outside.
- rply, dmr, sack  in  1 each  asynchronous bus inputs, active-high.
- dmgo  out  1  DMA grant.

## Operation
- rply, dmr and sack each pass through a two-flop synchronizer (rply_s, dmr_s, sack_s). The FSM uses only the synchronized versions.
- States: IDLE, ADDR, ASYNC, DATA, RELEASE, GRANT, DMA.
- IDLE: all bus outputs 0. If dmr_s, go to GRANT; dmr_s has priority over req. Otherwise, if req, latch addr/wdata/we/byte and go to ADDR.
- ADDR (1 cycle): ad_oe=1, ad_out=addr, wtbt=we, sync=0.
- ASYNC (1 cycle): as ADDR, plus sync=1.
- DATA: sync=1.
  - Read: ad_oe=0, din=1.
  - Write: ad_oe=1, ad_out=wdata, dout=1, wtbt=byte.
  - When rply_s=1: for a read, capture rdata<=ad_in; go to RELEASE.
  - After TIMEOUT consecutive DATA cycles without rply_s: go to IDLE with ack=1, err=1.
- RELEASE: din=dout=0, ad_oe=0, sync=1. When rply_s=0: go to IDLE with ack=1, err=0. After TIMEOUT cycles with rply_s still 1: go to IDLE with ack=1, err=1.
- GRANT: dmgo=1.
  - sack_s=1: go to DMA.
  - dmr_s=0 before sack_s: withdraw dmgo and return to IDLE.
- DMA: dmgo=0, all bus outputs 0 or released; stay while sack_s=1, go to IDLE on sack_s=0.
- Latched request fields are used throughout the cycle. If req or addr change after acceptance, the cycle is unaffected.
- A new req held high in the ack cycle is accepted no earlier than the next IDLE cycle.
- The timeout counter is $clog2(TIMEOUT+1) bits wide. It clears on entry to DATA and to RELEASE, and saturates.

## Timing
- Reset (asynchronous assert): state=IDLE; sync, din, dout, wtbt, ad_oe, dmgo, ack, err, busy = 0; ad_out=0; rdata=0; synchronizers cleared.
- Reset mid-cycle releases the bus immediately; no ack is issued.
- Reset deassertion is used synchronously through the FSM.
- With req high in IDLE at cycle N: ADDR at N+1, ASYNC at N+2, DATA at N+3.
- Synchronizer latency: rply rising before edge k is visible as rply_s at k+2.
- Minimum cycle with a zero-delay responder is 9 clocks, req-accept to ack inclusive.
- ack, err and the rdata update are registered outputs. They are asserted in the first IDLE cycle after the terminating transition.
- dmgo rises the cycle after IDLE sees dmr_s, and falls the cycle after sack_s is seen.

## Structure
- Shared package qbus_pkg holds:
  - state enum encodings;
  - default TIMEOUT;
  - the ack/err encoding constant used by the core.
- Sub-module sync2: two-flop synchronizer with async active-low clear, instantiated three times.

## Test plan
- Read: addr=0xE0C0, responder drives ad_in=0x1234 and asserts rply 2 clocks after din -> correct state sequence, rdata=0x1234, single ack, err=0, din drops before sync.
- Byte write: addr=0x0200, wdata=0x00A5, byte=1 -> wtbt=1 in ADDR/ASYNC (we), wtbt=1 in DATA (byte), ad_out=0x00A5 with dout=1, ack after rply drops.
- Timeout: no rply, TIMEOUT=64 -> exactly 64 DATA cycles, then ack=err=1, sync=din=0.
- DMA priority: dmr and req asserted together in IDLE -> dmgo=1, no sync. After sack high then low, the CPU read runs.
- DMA withdrawal: dmr pulse of 3 clocks without sack -> dmgo asserted, then cleared, back to IDLE.
- Reset mid-DATA: reset_n low during a read -> all outputs 0 asynchronously, no ack; next req completes normally.

Source files
------------

// File: rtl/qbus_pkg.sv
// Shared Q-bus definitions: FSM state encodings, default RPLY timeout and the
// {ack, err} completion encoding consumed by the core.
package qbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_ASYNC   = 3'd2,
    ST_DATA    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_GRANT   = 3'd5,
    ST_DMA     = 3'd6
  } state_e;

  localparam int unsigned DEF_TIMEOUT = 64;

  typedef struct packed {
    logic ack;
    logic err;
  } resp_t;

  localparam resp_t RESP_NONE = '{ack: 1'b0, err: 1'b0};
  localparam resp_t RESP_OK   = '{ack: 1'b1, err: 1'b0};
  localparam resp_t RESP_ERR  = '{ack: 1'b1, err: 1'b1};

  typedef struct packed {
    logic        we;
    logic        wbyte;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous bus input; two cycles of latency,
// both flops cleared by the asynchronous active-low reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/qbus_ctl.sv
// Q-bus cycle sequencer and DMA arbiter: ADDR/ASYNC/DATA/RELEASE handshake,
// ack/err/rdata registered into the first IDLE cycle; DMA wins over the core.
module qbus_ctl
  import qbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic        wbyte,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  input  logic [15:0] ad_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  output logic        sync,
  output logic        din,
  output logic        dout,
  output logic        wtbt,
  input  logic        rply,
  input  logic        dmr,
  input  logic        sack,
  output logic        dmgo
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT);

  logic rply_s;
  logic dmr_s;
  logic sack_s;

  sync2 u_sync_rply (.clk(clk), .rst_n(reset_n), .d_i(rply), .q_o(rply_s));
  sync2 u_sync_dmr  (.clk(clk), .rst_n(reset_n), .d_i(dmr),  .q_o(dmr_s));
  sync2 u_sync_sack (.clk(clk), .rst_n(reset_n), .d_i(sack), .q_o(sack_s));

  state_e       state_q, state_d;
  req_t         req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  resp_t        resp_q, resp_d;
  logic [15:0]  cap_q, cap_d;
  logic [15:0]  rdata_q, rdata_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= RESP_NONE;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    resp_d  = RESP_NONE;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // A request seen during the ack cycle waits one more IDLE cycle.
        if (dmr_s) begin
          state_d = ST_GRANT;
        end else if (req && !resp_q.ack) begin
          req_d   = '{we: we, wbyte: wbyte, addr: addr, wdata: wdata};
          state_d = ST_ADDR;
        end
      end
      ST_ADDR:  state_d = ST_ASYNC;
      ST_ASYNC: begin
        cnt_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (rply_s) begin
          if (!req_q.we) cap_d = ad_in;
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          resp_d  = RESP_ERR;
          state_d = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (!rply_s || cnt_q == CNT_LAST) begin
          resp_d  = rply_s ? RESP_ERR : RESP_OK;
          if (!req_q.we) rdata_d = cap_q;
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (sack_s)      state_d = ST_DMA;
        else if (!dmr_s) state_d = ST_IDLE;
      end
      ST_DMA: begin
        if (!sack_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sync   = 1'b0;
    din    = 1'b0;
    dout   = 1'b0;
    wtbt   = 1'b0;
    ad_oe  = 1'b0;
    ad_out = '0;
    dmgo   = 1'b0;
    busy   = (state_q != ST_IDLE);
    case (state_q)
      ST_ADDR: begin
        ad_oe  = 1'b1;
        ad_out = req_q.addr;
        wtbt   = req_q.we;
      end
      ST_ASYNC: begin
        ad_oe  = 1'b1;
        ad_out = req_q.addr;
        wtbt   = req_q.we;
        sync   = 1'b1;
      end
      ST_DATA: begin
        sync = 1'b1;
        if (req_q.we) begin
          ad_oe  = 1'b1;
          ad_out = req_q.wdata;
          dout   = 1'b1;
          wtbt   = req_q.wbyte;
        end else begin
          din = 1'b1;
        end
      end
      ST_RELEASE: sync = 1'b1;
      ST_GRANT:   dmgo = 1'b1;
      default: ;
    endcase
  end

  assign ack   = resp_q.ack;
  assign err   = resp_q.err;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_qbus_ctl.sv
module tb_qbus_ctl;

  logic        clk;
  logic        reset_n;
  logic        req, we, wbyte;
  logic [15:0] addr, wdata;
  logic [15:0] rdata;
  logic        ack, err, busy;
  logic [15:0] ad_in, ad_out;
  logic        ad_oe, sync, din, dout, wtbt;
  logic        rply, dmr, sack, dmgo;

  qbus_ctl #(.TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req(req), .we(we), .wbyte(wbyte), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .sync(sync), .din(din), .dout(dout), .wtbt(wtbt),
    .rply(rply), .dmr(dmr), .sack(sack), .dmgo(dmgo)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;

  // Responder: mode 0 normal, 1 never replies, 2 never releases rply.
  int          resp_mode;
  int          resp_dly;
  logic [15:0] resp_data;
  int          strb_cnt;

  typedef struct {
    logic        we;
    logic        wbyte;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] resp;
    int          dly;
    int          mode;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_strb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (din || dout) begin
      strb_cnt++;
      if (resp_mode != 1 && strb_cnt > resp_dly) begin
        rply  = 1'b1;
        ad_in = resp_data;
      end
    end else begin
      strb_cnt = 0;
      if (resp_mode != 2) rply = 1'b0;
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (!ack && n < 200) begin
      step();
      n++;
    end
    chk("wait_ack_seen", ack, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int off, strb;
    bit saw_rel, got;
    resp_mode = v.mode;
    resp_dly  = v.dly;
    resp_data = v.resp;
    ad_in     = 16'h0BAD;
    req = 1'b1; we = v.we; wbyte = v.wbyte; addr = v.addr; wdata = v.wdata;
    step();
    off = 1;
    // Scramble the request inputs to prove the cycle runs on latched fields.
    req = 1'b0; we = ~v.we; wbyte = ~v.wbyte; addr = ~v.addr; wdata = ~v.wdata;
    chk($sformatf("v%0d_addr_oe", idx), ad_oe, 1);
    chk($sformatf("v%0d_addr_out", idx), ad_out, v.addr);
    chk($sformatf("v%0d_addr_sync", idx), sync, 0);
    chk($sformatf("v%0d_addr_wtbt", idx), wtbt, v.we);
    chk($sformatf("v%0d_addr_busy", idx), busy, 1);
    step();
    off = 2;
    chk($sformatf("v%0d_async_sync", idx), sync, 1);
    chk($sformatf("v%0d_async_out", idx), ad_out, v.addr);
    chk($sformatf("v%0d_async_wtbt", idx), wtbt, v.we);
    strb = 0; saw_rel = 0; got = 0;
    while (!got && off < 300) begin
      step();
      off++;
      if (din || dout) begin
        if (strb == 0) begin
          chk($sformatf("v%0d_data_sync", idx), sync, 1);
          chk($sformatf("v%0d_data_din", idx), din, !v.we);
          chk($sformatf("v%0d_data_dout", idx), dout, v.we);
          chk($sformatf("v%0d_data_oe", idx), ad_oe, v.we);
          if (v.we) begin
            chk($sformatf("v%0d_data_out", idx), ad_out, v.wdata);
            chk($sformatf("v%0d_data_wtbt", idx), wtbt, v.wbyte);
          end
        end
        strb++;
      end else if (sync && strb > 0) begin
        saw_rel = 1;
      end
      if (ack) got = 1;
    end
    chk($sformatf("v%0d_ack_seen", idx), got, 1);
    chk($sformatf("v%0d_latency", idx), off, v.exp_lat);
    chk($sformatf("v%0d_err", idx), err, v.exp_err);
    chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
    chk($sformatf("v%0d_ack_sync", idx), {sync, din, dout, busy}, 0);
    chk($sformatf("v%0d_strobes", idx), strb, v.exp_strb);
    chk($sformatf("v%0d_release", idx), saw_rel, (v.mode != 1));
  endtask

  initial begin
    int n;
    bit got;
    vec_t v;
    checks = 0; failures = 0;
    clk = 1'b0; reset_n = 1'b0;
    req = 1'b0; we = 1'b0; wbyte = 1'b0; addr = '0; wdata = '0;
    ad_in = '0; rply = 1'b0; dmr = 1'b0; sack = 1'b0;
    resp_mode = 0; resp_dly = 0; resp_data = '0; strb_cnt = 0;

    vecs[0] = '{we:0, wbyte:0, addr:16'hE0C0, wdata:16'h0000, resp:16'h1234, dly:2, mode:0,
                exp_rdata:16'h1234, exp_err:0, exp_lat:11, exp_strb:5};
    vecs[1] = '{we:1, wbyte:1, addr:16'h0200, wdata:16'h00A5, resp:16'h0000, dly:0, mode:0,
                exp_rdata:16'h1234, exp_err:0, exp_lat:9, exp_strb:3};
    vecs[2] = '{we:1, wbyte:0, addr:16'h1000, wdata:16'hBEEF, resp:16'h0000, dly:1, mode:0,
                exp_rdata:16'h1234, exp_err:0, exp_lat:10, exp_strb:4};
    vecs[3] = '{we:0, wbyte:0, addr:16'hFF70, wdata:16'h0000, resp:16'hA5A5, dly:0, mode:0,
                exp_rdata:16'hA5A5, exp_err:0, exp_lat:9, exp_strb:3};
    vecs[4] = '{we:0, wbyte:0, addr:16'h0040, wdata:16'h0000, resp:16'h7777, dly:0, mode:1,
                exp_rdata:16'hA5A5, exp_err:1, exp_lat:67, exp_strb:64};
    vecs[5] = '{we:1, wbyte:0, addr:16'h0300, wdata:16'h0F0F, resp:16'h0000, dly:0, mode:2,
                exp_rdata:16'hA5A5, exp_err:1, exp_lat:70, exp_strb:3};
    vecs[6] = '{we:0, wbyte:0, addr:16'h2468, wdata:16'h0000, resp:16'h8001, dly:4, mode:0,
                exp_rdata:16'h8001, exp_err:0, exp_lat:13, exp_strb:7};

    #12;
    chk("rst_ctrl", {sync, din, dout, wtbt, ad_oe, dmgo}, 0);
    chk("rst_resp", {ack, err, busy}, 0);
    chk("rst_ad_out", ad_out, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    step();

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
      resp_mode = 0;
      step();
      chk($sformatf("v%0d_ack_pulse", i), {ack, err}, 0);
      repeat (3) step();
    end

    // DMA request already synchronized when the core asks: DMA wins.
    dmr = 1'b1;
    step();
    step();
    req = 1'b1; we = 1'b0; addr = 16'h0100;
    resp_mode = 0; resp_dly = 0; resp_data = 16'h5555;
    step();
    chk("dma_grant", dmgo, 1);
    chk("dma_no_sync", {sync, ad_oe}, 0);
    chk("dma_busy", busy, 1);
    sack = 1'b1;
    step();
    chk("dma_hold1", dmgo, 1);
    step();
    chk("dma_hold2", dmgo, 1);
    step();
    chk("dma_dmgo_drop", dmgo, 0);
    chk("dma_state_busy", {busy, sync}, 2'b10);
    dmr = 1'b0; sack = 1'b0;
    step();
    step();
    step();
    chk("dma_exit_idle", busy, 0);
    step();
    chk("dma_cpu_addr", {busy, ad_oe, sync}, 3'b110);
    chk("dma_cpu_ad", ad_out, 16'h0100);
    req = 1'b0;
    wait_ack(n);
    chk("dma_cpu_lat", n, 8);
    chk("dma_cpu_rdata", rdata, 16'h5555);
    chk("dma_cpu_err", err, 0);
    repeat (3) step();

    // Three-clock DMR pulse with no SACK.
    dmr = 1'b1;
    step();
    step();
    chk("wd_c2", dmgo, 0);
    step();
    chk("wd_c3", dmgo, 1);
    dmr = 1'b0;
    step();
    chk("wd_c4", dmgo, 1);
    step();
    chk("wd_c5", dmgo, 1);
    step();
    chk("wd_c6", {dmgo, busy}, 0);
    repeat (2) step();

    // Request held into the ack cycle is taken one IDLE cycle later.
    v = '{we:0, wbyte:0, addr:16'h0500, wdata:16'h0000, resp:16'h4242, dly:0, mode:0,
          exp_rdata:16'h4242, exp_err:0, exp_lat:9, exp_strb:3};
    run_vec(v, 7);
    req = 1'b1; we = 1'b0; addr = 16'h0700;
    resp_data = 16'h1357;
    step();
    chk("ackcyc_no_accept", busy, 0);
    step();
    chk("ackcyc_accept", busy, 1);
    chk("ackcyc_addr", ad_out, 16'h0700);
    req = 1'b0;
    wait_ack(n);
    chk("ackcyc_lat", n, 8);
    chk("ackcyc_rdata", rdata, 16'h1357);
    repeat (3) step();

    // Reset asserted in the middle of a read's data phase.
    resp_mode = 1;
    req = 1'b1; we = 1'b0; addr = 16'h0600;
    step();
    req = 1'b0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (din) got = 1;
    end
    chk("rstmid_din", got, 1);
    step();
    #1;
    reset_n = 1'b0;
    #1;
    chk("rstmid_ctrl", {sync, din, dout, wtbt, ad_oe, dmgo}, 0);
    chk("rstmid_resp", {ack, err, busy}, 0);
    chk("rstmid_rdata", rdata, 0);
    step();
    step();
    reset_n = 1'b1;
    resp_mode = 0;
    step();
    chk("rstmid_no_ack", {ack, busy}, 0);
    step();
    v = '{we:0, wbyte:0, addr:16'h0610, wdata:16'h0000, resp:16'h2222, dly:1, mode:0,
          exp_rdata:16'h2222, exp_err:0, exp_lat:10, exp_strb:4};
    run_vec(v, 8);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
